apu_mixer: RTL and testbench
============================

# apu_mixer

Sequential audio mixer between the four APU channel generators and the PWM output converters. On each sample strobe it snapshots the four 4-bit channel levels, sums the enabled ones serially, scales by a 3-bit master volume, and applies a soft-mute gain ramp so enable and mute changes do not pop. It produces the 6-bit mixed sample that feeds the mixed-audio PWM converter, and runs in the divided GameBoy clock domain.

## Interface
Parameters (only the defaults are verified):
- NUM_CH, 4, number of channel inputs
- CH_BITS, 4, width of each channel level
- OUT_BITS, 6, width of the mixed output; must be at least CH_BITS + log2(NUM_CH)
- VOL_BITS, 3, master volume width

Ports:
- clk  in  1  GameBoy-domain clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low; asserting low clears all state immediately
- sample_tick  in  1  single-cycle request to produce one sample
- ch1, ch2, ch3, ch4  in  4 each  channel levels, 0..15
- ch_en  in  4  per-channel enable; bit i gates ch(i+1)
- master_vol  in  3  volume code 0..7; the effective gain is (master_vol+1)/8
- mute  in  1  gain-ramp target select: 1 targets gain 0, 0 targets gain 8
- audio_out  out  6  mixed sample; held between updates
- out_valid  out  1  one-cycle pulse when audio_out updates
- busy  out  1  high while a sample is being computed
- overrun  out  1  sticky flag; set when sample_tick arrives while busy

## Operation
- The FSM has four states: IDLE, ACC, SCALE, OUT.
- **IDLE.** When sample_tick=1, snapshot ch1..ch4, ch_en, master_vol and mute into registers, clear acc and idx, then go to ACC. Otherwise stay in IDLE.
- **ACC.** Runs for 4 cycles, idx 0..3.
  - Each cycle: acc += snap_ch[idx] when snap_en[idx]=1, else acc += 0.
  - After idx=3, go to SCALE.
  - acc is 6 bits, maximum 60, so it never overflows.
- **SCALE.** scaled = (acc × (vol+1)) >> 3.
  - The product is 9 bits, maximum 480.
  - scaled is 6 bits, maximum 60.
  - Go to OUT.
- **OUT.** audio_out ← (scaled × gain) >> 3, using the gain value from before this cycle.
  - In the same cycle, gain steps one toward its target: +1 if below 8 and snap_mute=0; −1 if above 0 and snap_mute=1; unchanged otherwise.
  - gain is a 4-bit register, range 0..8.
  - out_valid pulses. Return to IDLE.
- **busy.** busy=1 in ACC, SCALE and OUT.
- **Tick while busy.** A sample_tick that arrives while busy=1 is dropped and sets overrun=1. overrun stays set until reset.
- **Simultaneous return and tick.** A sample_tick in the same cycle the FSM enters IDLE (the cycle after OUT) is accepted normally.
- **Reset values.**
  - Outputs: audio_out=0, out_valid=0, busy=0, overrun=0.
  - Internal: state=IDLE, gain=0, acc=0.
  - Because gain resets to 0, the first 8 samples after reset ramp up from silence.
- **Reset mid-computation.** Reset asserted during a computation abandons it: no out_valid is produced and all registers return to their reset values.

## Timing
- Let E0 be the edge that samples sample_tick=1 in IDLE.
- ACC occupies edges E1..E4, SCALE is E5, and OUT is E6.
- audio_out and out_valid become visible after E6, so latency is 6 cycles from tick to output.
- out_valid is high for exactly the cycle after E6.
- busy is high from after E0 through the cycle ending at E6.
- The earliest next accepted tick is at E7, giving a minimum sample period of 7 cycles.
- Inputs are don't-care after E0; only the snapshot is used.
- Ramp timing: the gain change takes full effect over 8 samples. A mute toggle mid-ramp reverses direction on the next sample.

## Test plan
- **Reset.** Assert reset low mid-ACC, then release. Required: all outputs 0, no out_valid, busy=0; the next tick produces out_valid after 6 cycles.
- **Ramp-up from reset.** ch1..ch4=15, ch_en=4'b1111, vol=7, mute=0, nine ticks spaced 10 cycles apart. Required audio_out sequence: 0, 7, 15, 22, 30, 37, 45, 52, 60; the tenth tick also gives 60.
- **Enable masking and volume.** Start from steady gain 8 with ch1=15, ch2=9, ch3=4, ch4=1.
  - ch_en=4'b0001, vol=7 → 15.
  - ch_en=4'b0110, vol=7 → 13.
  - ch_en=4'b1111, vol=0 → 3, since 29×1>>3 = 3.
  - ch_en=4'b1111, vol=3 → 14, since 29×4>>3 = 14.
- **Mute ramp-down.** From gain 8 with mixed value 60, assert mute=1 and tick nine times. Required: 60, 52, 45, 37, 30, 22, 15, 7, 0.
- **Overrun and back-to-back.**
  - A tick at E0 plus a tick at E3: the second tick is dropped, overrun=1, and only one out_valid occurs.
  - A tick at E7: accepted, with out_valid after E13.
- **Snapshot isolation.** Change ch1..ch4, ch_en, vol and mute on E1..E5. Required: the output matches the values sampled at E0.

Source files
------------

// File: rtl/apu_mixer.sv
// apu_mixer: serial four-channel audio mixer with master volume and soft-mute gain ramp.
// On each accepted sample_tick the channel levels are snapshotted, summed one channel per
// cycle, scaled by (master_vol+1)/8, then multiplied by a slowly ramping gain (0..8)/8 so
// that mute and enable changes fade in and out instead of clicking.
module apu_mixer #(
   parameter int NUM_CH   = 4,
   parameter int CH_BITS  = 4,
   parameter int OUT_BITS = 6,
   parameter int VOL_BITS = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                sample_tick,
   input  logic [CH_BITS-1:0]  ch1,
   input  logic [CH_BITS-1:0]  ch2,
   input  logic [CH_BITS-1:0]  ch3,
   input  logic [CH_BITS-1:0]  ch4,
   input  logic [NUM_CH-1:0]   ch_en,
   input  logic [VOL_BITS-1:0] master_vol,
   input  logic                mute,
   output logic [OUT_BITS-1:0] audio_out,
   output logic                out_valid,
   output logic                busy,
   output logic                overrun
);

   localparam int IDX_BITS  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PROD_BITS = OUT_BITS + VOL_BITS;
   localparam logic [3:0] GAIN_MAX = 4'd8;
   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_CH - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACC,
      SCALE,
      OUT
   } state_t;

   state_t state;
   state_t next_state;

   logic [CH_BITS-1:0]  snap_ch [4];
   logic [NUM_CH-1:0]   snap_en;
   logic [VOL_BITS-1:0] snap_vol;
   logic                snap_mute;
   logic [OUT_BITS-1:0] acc;
   logic [IDX_BITS-1:0] idx;
   logic [OUT_BITS-1:0] scaled;
   logic [3:0]          gain;

   logic [OUT_BITS-1:0] addend;
   logic [VOL_BITS:0]   vol_plus;
   logic [PROD_BITS-1:0] vol_prod;
   logic [PROD_BITS-1:0] mix_prod;
   logic                unused_lsbs;

   // A disabled channel contributes zero so the accumulate step is always a plain add.
   assign addend = snap_en[idx] ? {{(OUT_BITS-CH_BITS){1'b0}}, snap_ch[idx]} : '0;

   // Both products are sized so that their worst case (60*8 = 480) fits without truncation.
   assign vol_plus = {1'b0, snap_vol} + {{VOL_BITS{1'b0}}, 1'b1};
   assign vol_prod = {{VOL_BITS{1'b0}}, acc} * {{(PROD_BITS-VOL_BITS-1){1'b0}}, vol_plus};
   assign mix_prod = {{VOL_BITS{1'b0}}, scaled} * {{(PROD_BITS-4){1'b0}}, gain};

   // The three bits shifted out by the divide-by-8 are intentionally discarded.
   assign unused_lsbs = ^{vol_prod[VOL_BITS-1:0], mix_prod[2:0]};

   assign busy = (state != IDLE);

   // State register; reset abandons any sample in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: one accumulate cycle per channel, then scale, then output.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (sample_tick) next_state = ACC;
         ACC:     if (idx == LAST_IDX) next_state = SCALE;
         SCALE:   next_state = OUT;
         OUT:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Datapath: snapshot, serial accumulate, volume scale, gain-ramped output and overrun flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 4; i++) snap_ch[i] <= '0;
         snap_en   <= '0;
         snap_vol  <= '0;
         snap_mute <= 1'b0;
         acc       <= '0;
         idx       <= '0;
         scaled    <= '0;
         gain      <= '0;
         audio_out <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (busy && sample_tick) overrun <= 1'b1;
         case (state)
            IDLE: begin
               if (sample_tick) begin
                  snap_ch[0] <= ch1;
                  snap_ch[1] <= ch2;
                  snap_ch[2] <= ch3;
                  snap_ch[3] <= ch4;
                  snap_en    <= ch_en;
                  snap_vol   <= master_vol;
                  snap_mute  <= mute;
                  acc        <= '0;
                  idx        <= '0;
               end
            end
            ACC: begin
               acc <= acc + addend;
               idx <= idx + IDX_BITS'(1);
            end
            SCALE: begin
               scaled <= vol_prod[PROD_BITS-1:VOL_BITS];
            end
            OUT: begin
               audio_out <= mix_prod[OUT_BITS+2:3];
               out_valid <= 1'b1;
               if (!snap_mute && gain < GAIN_MAX) begin
                  gain <= gain + 4'd1;
               end else if (snap_mute && gain != 4'd0) begin
                  gain <= gain - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_apu_mixer.sv
// tb_apu_mixer: randomized self-checking bench for apu_mixer against an arithmetic reference model.
module tb_apu_mixer;

   logic       clk;
   logic       reset;
   logic       sample_tick;
   logic [3:0] ch1, ch2, ch3, ch4;
   logic [3:0] ch_en;
   logic [2:0] master_vol;
   logic       mute;
   logic [5:0] audio_out;
   logic       out_valid;
   logic       busy;
   logic       overrun;

   int num_checks;
   int num_errors;
   int model_gain;

   apu_mixer dut (
      .clk         (clk),
      .reset       (reset),
      .sample_tick (sample_tick),
      .ch1         (ch1),
      .ch2         (ch2),
      .ch3         (ch3),
      .ch4         (ch4),
      .ch_en       (ch_en),
      .master_vol  (master_vol),
      .mute        (mute),
      .audio_out   (audio_out),
      .out_valid   (out_valid),
      .busy        (busy),
      .overrun     (overrun)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts one comparison and reports it when observed differs from expected.
   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      num_checks++;
      if (observed !== expected) begin
         num_errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Reference model: mean of the spec's rules in plain integer arithmetic; advances the gain ramp.
   task automatic model_step(input int c1, input int c2, input int c3, input int c4,
                             input int en, input int vol, input int mu, output int expected);
      int total;
      int scaled;
      int levels [4];
      levels = '{c1, c2, c3, c4};
      total = 0;
      for (int i = 0; i < 4; i++) if (en[i]) total += levels[i];
      scaled   = (total * (vol + 1)) / 8;
      expected = (scaled * model_gain) / 8;
      if (mu == 0 && model_gain < 8) model_gain++;
      else if (mu != 0 && model_gain > 0) model_gain--;
   endtask

   task automatic randomize_inputs();
      ch1        = 4'($urandom_range(0, 15));
      ch2        = 4'($urandom_range(0, 15));
      ch3        = 4'($urandom_range(0, 15));
      ch4        = 4'($urandom_range(0, 15));
      ch_en      = 4'($urandom_range(0, 15));
      master_vol = 3'($urandom_range(0, 7));
      mute       = 1'($urandom_range(0, 1));
   endtask

   // Issues one tick with the given inputs, optionally scrambles inputs during E1..E5,
   // and checks latency, pulse width, busy, and the mixed value against the model.
   task automatic apply_stimulus(input logic [3:0] c1, input logic [3:0] c2, input logic [3:0] c3,
                                 input logic [3:0] c4, input logic [3:0] en, input logic [2:0] vol,
                                 input logic mu, input bit perturb, output int result);
      int expected;
      int lat;
      int pulses;
      model_step(c1, c2, c3, c4, en, vol, mu, expected);
      @(negedge clk);
      ch1 = c1; ch2 = c2; ch3 = c3; ch4 = c4;
      ch_en = en; master_vol = vol; mute = mu;
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      check_output("busy_after_tick", busy, 1);
      lat = -1;
      pulses = 0;
      result = -1;
      for (int k = 1; k <= 12; k++) begin
         if (perturb && k <= 5) randomize_inputs();
         @(negedge clk);
         if (out_valid) begin
            pulses++;
            if (lat < 0) begin
               lat = k;
               result = int'(audio_out);
               check_output("busy_at_valid", busy, 0);
            end
         end
      end
      check_output("latency", lat, 6);
      check_output("valid_pulses", pulses, 1);
      check_output("audio_out", result, expected);
      check_output("audio_hold", audio_out, expected);
   endtask

   initial begin
      int res;
      int ramp_exp [10];
      int mute_exp [9];
      int lat1, lat2, pulses, got1, got2, exp1, exp2;
      num_checks  = 0;
      num_errors  = 0;
      model_gain  = 0;
      reset       = 1'b0;
      sample_tick = 1'b0;
      ch1 = 0; ch2 = 0; ch3 = 0; ch4 = 0;
      ch_en = 0; master_vol = 0; mute = 0;

      // Reset state.
      repeat (3) @(negedge clk);
      check_output("rst_audio_out", audio_out, 0);
      check_output("rst_out_valid", out_valid, 0);
      check_output("rst_busy", busy, 0);
      check_output("rst_overrun", overrun, 0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Ramp-up from silence.
      $display("[TB] ramp-up");
      ramp_exp = '{0, 7, 15, 22, 30, 37, 45, 52, 60, 60};
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(4'd15, 4'd15, 4'd15, 4'd15, 4'b1111, 3'd7, 1'b0, 1'b0, res);
         check_output($sformatf("ramp_%0d", i), res, ramp_exp[i]);
      end

      // Enable masking and volume at steady gain 8.
      $display("[TB] masking and volume");
      apply_stimulus(4'd15, 4'd9, 4'd4, 4'd1, 4'b0001, 3'd7, 1'b0, 1'b0, res);
      check_output("mask_0001", res, 15);
      apply_stimulus(4'd15, 4'd9, 4'd4, 4'd1, 4'b0110, 3'd7, 1'b0, 1'b0, res);
      check_output("mask_0110", res, 13);
      apply_stimulus(4'd15, 4'd9, 4'd4, 4'd1, 4'b1111, 3'd0, 1'b0, 1'b0, res);
      check_output("vol_0", res, 3);
      apply_stimulus(4'd15, 4'd9, 4'd4, 4'd1, 4'b1111, 3'd3, 1'b0, 1'b0, res);
      check_output("vol_3", res, 14);

      // Mute ramp-down from full scale.
      $display("[TB] mute ramp-down");
      mute_exp = '{60, 52, 45, 37, 30, 22, 15, 7, 0};
      for (int i = 0; i < 9; i++) begin
         apply_stimulus(4'd15, 4'd15, 4'd15, 4'd15, 4'b1111, 3'd7, 1'b1, 1'b0, res);
         check_output($sformatf("mute_%0d", i), res, mute_exp[i]);
      end

      // Randomized samples with inputs scrambled after the snapshot.
      $display("[TB] random samples with snapshot isolation");
      for (int i = 0; i < 25; i++) begin
         apply_stimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                        4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                        4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                        1'($urandom_range(0, 3) == 0), 1'b1, res);
      end

      // Overrun: tick at E0 and E3 (dropped), then at E7 (accepted).
      $display("[TB] overrun and back-to-back");
      check_output("overrun_before", overrun, 0);
      ch1 = 4'd12; ch2 = 4'd7; ch3 = 4'd3; ch4 = 4'd9;
      ch_en = 4'b1011; master_vol = 3'd5; mute = 1'b0;
      model_step(12, 7, 3, 9, 4'b1011, 5, 0, exp1);
      model_step(12, 7, 3, 9, 4'b1011, 5, 0, exp2);
      @(negedge clk);
      sample_tick = 1'b1;
      lat1 = -1; lat2 = -1; pulses = 0; got1 = -1; got2 = -1;
      for (int k = 0; k <= 16; k++) begin
         @(negedge clk);
         sample_tick = (k + 1 == 3) || (k + 1 == 7);
         if (k == 3) check_output("overrun_set", overrun, 1);
         if (out_valid) begin
            pulses++;
            if (lat1 < 0) begin
               lat1 = k; got1 = int'(audio_out);
            end else if (lat2 < 0) begin
               lat2 = k; got2 = int'(audio_out);
            end
         end
      end
      sample_tick = 1'b0;
      check_output("ovr_first_valid_edge", lat1, 6);
      check_output("ovr_second_valid_edge", lat2, 13);
      check_output("ovr_pulses", pulses, 2);
      check_output("ovr_first_value", got1, exp1);
      check_output("ovr_second_value", got2, exp2);
      repeat (3) @(negedge clk);
      check_output("overrun_sticky", overrun, 1);

      // Reset mid-ACC abandons the sample and restores every register.
      $display("[TB] reset mid-computation");
      ch1 = 4'd15; ch2 = 4'd15; ch3 = 4'd15; ch4 = 4'd15;
      ch_en = 4'b1111; master_vol = 3'd7; mute = 1'b0;
      @(negedge clk);
      sample_tick = 1'b1;
      @(negedge clk);
      sample_tick = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check_output("midrst_audio_out", audio_out, 0);
      check_output("midrst_out_valid", out_valid, 0);
      check_output("midrst_busy", busy, 0);
      check_output("midrst_overrun", overrun, 0);
      model_gain = 0;
      @(negedge clk);
      reset = 1'b1;
      pulses = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (out_valid) pulses++;
      end
      check_output("midrst_no_valid", pulses, 0);
      apply_stimulus(4'd15, 4'd15, 4'd15, 4'd15, 4'b1111, 3'd7, 1'b0, 1'b0, res);
      check_output("post_rst_0", res, 0);
      apply_stimulus(4'd15, 4'd15, 4'd15, 4'd15, 4'b1111, 3'd7, 1'b0, 1'b0, res);
      check_output("post_rst_1", res, 7);

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
